uart_rx_pipe: RTL and testbench
===============================

// Module: uart_rx_pipe
// PURPOSE
// - UART receiver for the pico2-ice design. Receives on ICE_27 (8N1, LSB first)
//   alongside the existing UART transmitter on ICE_25.
// - Oversamples the serial line with a baud counter, samples each bit at mid-bit
//   and checks the stop bit.
// - Delivers each byte on a valid/ready stream to downstream logic
//   (echo/command path, LED control).
// PARAMETERS
// - CLK_HZ     12000000  clock frequency in Hz
// - BAUD       115200    line rate; DIV = CLK_HZ/BAUD, truncating (104 at defaults)
// - DATA_BITS  8         data bits per frame, range 5..8
// PORTS
// - clk_12p0    in   1          system clock (12 MHz)
// - rst_n       in   1          asynchronous reset, active low
// - rx          in   1          serial input (ICE_27), idle high, asynchronous to clk
// - data        out  DATA_BITS  received byte; stable while valid=1
// - valid       out  1          byte available
// - ready       in   1          consumer accepts; transfer when valid&&ready
// - frame_err   out  1          1-cycle pulse: stop bit sampled 0
// - overrun     out  1          1-cycle pulse: byte completed while valid&&!ready
// - parity_err  out  1          1-cycle pulse, UART_RX_PARITY_EN builds only
// BEHAVIOUR
// - Reset values: data=0, valid=0, frame_err=0, overrun=0, parity_err=0,
//   state=IDLE, synchroniser flops=1.
// - Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s.
// - Baud counter: counts DIV-1 down to 0; a "tick" occurs at 0, then reload.
// - State machine:
//   - IDLE: rx_s==0 -> START; load counter with DIV/2-1.
//   - START: on tick, rx_s==0 -> DATA (reload DIV-1, bit index=0);
//     rx_s==1 -> IDLE (glitch rejected, no flags).
//   - DATA: on each tick, shift rx_s into shift[MSB], right-shift (LSB first).
//     After DATA_BITS ticks -> STOP (or PARITY when enabled).
//   - STOP: on tick, rx_s==1 -> deliver, then IDLE; rx_s==0 -> frame_err pulse,
//     byte discarded, -> BREAK.
//   - BREAK: wait for rx_s==1, then IDLE. A held-low line gives exactly one
//     frame_err, never repeated starts.
// - Deliver:
//   - If valid==0 or (valid&&ready) in the same cycle: load data, valid=1 the
//     next cycle.
//   - Else keep the old byte, drop the new one, pulse overrun.
// - valid clears the cycle after valid&&ready, unless a new byte loads in that
//   same cycle; valid then stays 1 with the new data.
// - Latency: valid rises 1 clk after the stop-bit mid-sample, which is about
//   9.5 bit times + 3 clk after the start edge on rx.
// - Back-to-back frames: IDLE is re-entered at mid-stop, so a start edge right
//   at the stop bit's end is caught.
// - Reset mid-frame: everything returns to the reset values at once. After
//   release, reception begins with the next falling edge of rx_s. The partial
//   frame in flight at reset is not recovered.
// - frame_err, overrun and parity_err are never asserted in the same cycle as
//   each other.
// CONFIGURATION
// - UART_RX_PARITY_EN defined: frame is 8E1. A PARITY state follows DATA.
//   - On tick, compare rx_s with the XOR of the data bits (even parity).
//   - Mismatch: pulse parity_err, discard the byte, still check the stop bit
//     (stop=0 then gives frame_err instead, and parity_err is not pulsed).
// - UART_RX_PARITY_EN undefined: no PARITY state; parity_err tied 0; frame 8N1.
// TESTING
// - 0x55 sent at DIV=104, ready=1 -> one valid pulse with data=0x55; no error
//   flags.
// - rx low for 20 clk, then high -> no valid, no frame_err, FSM back in IDLE.
// - Frame 0xA3 with stop bit=0 -> frame_err pulse, valid stays 0. Holding rx low
//   for 5 bit times gives only one frame_err.
// - 0x11 then 0x22 back-to-back, ready=0 -> data=0x11 held, overrun pulse at the
//   2nd stop. ready=1 -> 0x11 taken, valid drops.
// - rst_n low at bit 4 of 0x3C, released, then 0xC3 sent -> valid with 0xC3
//   only; all outputs 0 while in reset.
// - PARITY build: 0xA5 with parity bit 1 (wrong) -> parity_err pulse, no valid.
//   Same byte with parity 0 -> valid with data=0xA5.

Source files
------------

// File: rtl/uart_rx_pipe.sv
// uart_rx_pipe: UART receiver (8N1, LSB first) for the pico2-ice serial input.
// A 2-flop synchroniser feeds a start/data/stop state machine that samples each
// bit at mid-bit using a baud down-counter. Received bytes leave on a one-deep
// valid/ready register. frame_err and overrun are single-cycle status pulses.
// Optional build macro: UART_RX_PARITY_EN selects 8E1 framing. A PARITY state
// then follows DATA, and parity_err reports even-parity mismatches.
module uart_rx_pipe #(
    parameter int CLK_HZ    = 12000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_12p0,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV + 1);
    localparam int IDX_W = 3;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity: the transmitted parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] bits);
        even_parity = ^bits;
    endfunction
`endif

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 frame_err_r;
    logic                 overrun_r;
    logic                 tick_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_r;
    logic                 parity_err_r;
`endif

    assign tick_s = (cnt_r == CNT_ZERO);

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk_12p0 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Frame state machine, baud counter, shifter and registered output stream
    always_ff @(posedge clk_12p0 or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            idx_r       <= IDX_ZERO;
            shift_r     <= {DATA_BITS{1'b0}};
            data_r      <= {DATA_BITS{1'b0}};
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            // A completed handshake empties the output register unless a new
            // byte is loaded below in the same cycle.
            if (valid_r && ready) begin
                valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (!rx_sync_r) begin
                        state_r <= ST_START;
                        cnt_r   <= CNT_HALF;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        if (!rx_sync_r) begin
                            state_r <= ST_DATA;
                            cnt_r   <= CNT_FULL;
                            idx_r   <= IDX_ZERO;
                        end else begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        shift_r <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        cnt_r   <= CNT_FULL;
                        if (idx_r == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_s) begin
                        par_bad_r <= (rx_sync_r != even_parity(shift_r));
                        cnt_r     <= CNT_FULL;
                        state_r   <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_s) begin
                        if (rx_sync_r) begin
                            // Back to IDLE at mid-stop so an immediately
                            // following start edge is not missed.
                            state_r <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad_r) begin
                                parity_err_r <= 1'b1;
                            end else
`endif
                            if (!valid_r || ready) begin
                                data_r  <= shift_r;
                                valid_r <= 1'b1;
                            end else begin
                                overrun_r <= 1'b1;
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    // A held-low line must not look like a train of start bits.
                    if (rx_sync_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign data      = data_r;
    assign valid     = valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_pipe.sv
// Self-checking bench for uart_rx_pipe: bit-banged frames on rx, a transaction
// monitor on the output stream, and a one-deep-buffer reference model.
`timescale 1ns/1ps
module tb_uart_rx_pipe;
    localparam int CLK_HZ    = 12000000;
    localparam int BAUD      = 115200;
    localparam int DATA_BITS = 8;
    localparam int DIV       = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk_12p0 = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx       = 1'b1;
    logic       ready    = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    int fe_exp = 0, ov_exp = 0, pe_exp = 0;
    logic [7:0] acc_q[$];
    logic [7:0] exp_q[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    longint     t_start = 0;
    longint     t_rise  = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] rb;
    int         lat;

    uart_rx_pipe #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS)) dut (
        .clk_12p0   (clk_12p0),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk_12p0 = ~clk_12p0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Output monitor: samples 2 ns after the falling edge, between input
    // changes (falling edge) and the DUT's active (rising) edge.
    initial forever begin
        @(negedge clk_12p0);
        #2;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_data  = 8'h00;
        end else begin
            if (valid && ready) acc_q.push_back(data);
            if (valid && !prev_valid) t_rise = $time;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (parity_err) pe_cnt++;
            if (frame_err || overrun || parity_err)
                check("flags_onehot", 32'(frame_err) + 32'(overrun) + 32'(parity_err), 32'd1);
            if (prev_valid && !prev_ready && valid)
                check("data_stable", 32'(data), 32'(prev_data));
            prev_valid = valid;
            prev_ready = ready;
            prev_data  = data;
        end
    end

    // ---------------- reference model (transaction level) ----------------
    task automatic model_deliver(input logic [7:0] b);
        if (m_valid) begin
            ov_exp++;
        end else if (ready) begin
            exp_q.push_back(b);
            m_data = b;
        end else begin
            m_valid = 1'b1;
            m_data  = b;
        end
    endtask

    task automatic set_ready(input logic r);
        ready = r;
        if (r && m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
        end
    endtask

    // ---------------- line driver (called at a falling edge) --------------
    task automatic hold_bits(input logic b, input int nclk);
        rx = b;
        repeat (nclk) @(negedge clk_12p0);
    endtask

    task automatic frame(input logic [7:0] b, input logic stop_b, input logic par_bad);
        t_start = $time;
        hold_bits(1'b0, DIV);
        for (int i = 0; i < DATA_BITS; i++) hold_bits(b[i], DIV);
        if (PAR == 1) hold_bits((^b) ^ par_bad, DIV);
        hold_bits(stop_b, DIV);
        if (!stop_b) fe_exp++;
        else if (par_bad) pe_exp++;
        else model_deliver(b);
    endtask

    task automatic checkpoint(input string tag);
        #2;
        check({tag, "_valid"}, 32'(valid), 32'(m_valid));
        check({tag, "_data"}, 32'(data), 32'(m_data));
        check({tag, "_frame_err"}, 32'(fe_cnt), 32'(fe_exp));
        check({tag, "_overrun"}, 32'(ov_cnt), 32'(ov_exp));
        check({tag, "_parity_err"}, 32'(pe_cnt), 32'(pe_exp));
        check({tag, "_nbytes"}, 32'(acc_q.size()), 32'(exp_q.size()));
        @(negedge clk_12p0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_12p0);
        checkpoint("reset");
        rst_n = 1'b1;
        hold_bits(1'b1, 2 * DIV);

        // 0x55 with ready=1, plus start-edge-to-valid latency
        set_ready(1'b1);
        t_rise = 0;
        frame(8'h55, 1'b1, 1'b0);
        hold_bits(1'b1, DIV);
        lat = int'((t_rise - t_start - 12) / 10 + 1);
        check("latency", 32'(lat), 32'((1 + DATA_BITS + PAR) * DIV + DIV / 2 + 3));
        checkpoint("byte55");

        // Short low glitch: rejected, no flags
        hold_bits(1'b0, 20);
        hold_bits(1'b1, 3 * DIV);
        checkpoint("glitch");

        // Bad stop bit, then line held low for 5 bit times: one frame_err
        frame(8'hA3, 1'b0, 1'b0);
        hold_bits(1'b0, 5 * DIV);
        hold_bits(1'b1, 2 * DIV);
        checkpoint("break");

        // Random bytes, random idle gaps (including back-to-back)
        for (int k = 0; k < 12; k++) begin
            hold_bits(1'b1, int'($urandom_range(0, 3)) * DIV);
            rb = 8'($urandom);
            frame(rb, 1'b1, 1'b0);
        end
        hold_bits(1'b1, DIV);
        checkpoint("random");

        // Back-to-back 0x11, 0x22 with ready=0: first held, second overruns
        set_ready(1'b0);
        hold_bits(1'b1, DIV);
        frame(8'h11, 1'b1, 1'b0);
        frame(8'h22, 1'b1, 1'b0);
        hold_bits(1'b1, DIV);
        checkpoint("overrun");
        set_ready(1'b1);
        repeat (3) @(negedge clk_12p0);
        checkpoint("drain");

`ifdef UART_RX_PARITY_EN
        // Wrong parity, right parity, wrong parity with bad stop
        frame(8'hA5, 1'b1, 1'b1);
        frame(8'hA5, 1'b1, 1'b0);
        frame(8'h5A, 1'b0, 1'b1);
        hold_bits(1'b1, 2 * DIV);
        checkpoint("parity");
`endif

        // Reset in the middle of 0x3C while 0x77 is still pending
        set_ready(1'b0);
        frame(8'h77, 1'b1, 1'b0);
        hold_bits(1'b1, DIV);
        checkpoint("pending");
        rb = 8'h3C;
        hold_bits(1'b0, DIV);
        for (int i = 0; i < 4; i++) hold_bits(rb[i], DIV);
        hold_bits(rb[4], DIV / 2);
        rst_n = 1'b0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        rx = 1'b1;
        repeat (10) @(negedge clk_12p0);
        checkpoint("in_reset");
        rst_n = 1'b1;
        set_ready(1'b1);
        hold_bits(1'b1, 2 * DIV);
        frame(8'hC3, 1'b1, 1'b0);
        hold_bits(1'b1, DIV);
        checkpoint("after_reset");

        // Every accepted byte, in order
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
            check("acc_byte", 32'(acc_q[i]), 32'(exp_q[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
